// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types, defaults and sizing helpers for sync_fifo_param
package fifo_pkg;

    // Read-mode encoding: registered read or first-word-fall-through.
    typedef enum logic {
        RD_STD  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_AE_LVL = 2;
    localparam int DEF_FWFT   = 0;

    // Pointer width: address bits for a DEPTH-entry array.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Count width: one extra bit so the value DEPTH is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - DATA_W x DEPTH register array, sync write, async read
// Ports:
//   clk      - write clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address
//   o_rdata  - combinational read data at i_raddr
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // Contents are deliberately not reset; occupancy tracking makes stale
    // entries unobservable.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds, flush and FWFT
// Ports:
//   clk, rst (sync active-low), flush (sync clear)
//   wr/din        - write request and data
//   rd            - read request (pop in FWFT mode)
//   dout          - read data (registered, or fall-through when FWFT=1)
//   full/empty/almost_full/almost_empty - registered occupancy flags
//   fifo_cnt      - occupancy
//   overflow/underflow - one-cycle pulses for dropped write / rejected read
//   wr_ptr/rd_ptr - debug pointers
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = DEF_AE_LVL,
    parameter int FWFT   = DEF_FWFT,
    localparam int PW    = ptr_w(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     fifo_cnt,
    output logic              overflow,
    output logic              underflow,
    output logic [PW-1:0]     wr_ptr,
    output logic [PW-1:0]     rd_ptr
);

    localparam rd_mode_e MODE = (FWFT != 0) ? RD_FWFT : RD_STD;

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
    end
    if (!((AE_LVL > 0) && (AE_LVL < AF_LVL) && (AF_LVL <= DEPTH))) begin : g_bad_lvl
        $error("sync_fifo_param: need 0 < AE_LVL < AF_LVL <= DEPTH");
    end

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_cnt;
    logic              r_full;
    logic              r_empty;
    logic              r_af;
    logic              r_ae;
    logic              r_ovf;
    logic              r_unf;
    logic [DATA_W-1:0] r_dout;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_we;
    logic [CW-1:0]     w_cnt_nxt;
    logic [DATA_W-1:0] w_mem_rdata;

    // A write into a full FIFO is still accepted when a read frees a slot
    // on the same edge.
    assign w_rd_acc = rd && !r_empty;
    assign w_wr_acc = wr && (!r_full || w_rd_acc);
    assign w_we     = rst && !flush && w_wr_acc;

    always_comb begin
        w_cnt_nxt = r_cnt;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_cnt_nxt = r_cnt + CW'(1);
            2'b01:   w_cnt_nxt = r_cnt - CW'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_dout   <= '0;
        end else if (flush) begin
            // Same as reset except the registered read data is kept.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_dout   <= w_mem_rdata;
            end
            r_cnt   <= w_cnt_nxt;
            // Flags come from the next-state count so they line up with fifo_cnt.
            r_full  <= (w_cnt_nxt == CW'(DEPTH));
            r_empty <= (w_cnt_nxt == '0);
            r_af    <= (w_cnt_nxt >= CW'(AF_LVL));
            r_ae    <= (w_cnt_nxt <= CW'(AE_LVL));
            r_ovf   <= wr && !w_wr_acc;
            r_unf   <= rd && r_empty;
        end
    end

    // Fall-through mode shows the head entry directly and forces 0 when empty.
    assign dout = (MODE == RD_FWFT) ? (r_empty ? '0 : w_mem_rdata) : r_dout;

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign fifo_cnt     = r_cnt;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
    assign wr_ptr       = r_wr_ptr;
    assign rd_ptr       = r_rd_ptr;

endmodule
